// File: rtl/matrix_job_arbiter.sv
// Round-robin arbiter that hands one matrix-multiply engine to one of NUM_REQ
// requesters and runs the engine start/complete/release handshake for the owner.
module matrix_job_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DIM_W     = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                     CLOCK_25,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*DIM_W-1:0] i_f_row_size,
  input  logic [NUM_REQ*DIM_W-1:0] i_f_col_size,
  input  logic [NUM_REQ*DIM_W-1:0] i_s_col_size,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_done,
  output logic [NUM_REQ-1:0]       o_err,
  output logic                     o_start,
  output logic [DIM_W-1:0]         o_f_row_size,
  output logic [DIM_W-1:0]         o_f_col_size,
  output logic [DIM_W-1:0]         o_s_col_size,
  input  logic                     i_eng_finished,
  input  logic                     i_eng_done,
  output logic [3:0]               o_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_ARM      = 4'd2,
    S_RUN      = 4'd3,
    S_RELEASE  = 4'd4,
    S_ABORT    = 4'd5,
    S_REJECT   = 4'd6,
    S_RESP_OK  = 4'd7,
    S_RESP_ERR = 4'd8
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr;
  logic [IDX_W-1:0]     pick;
  logic [TIMEOUT_W-1:0] wd;
  logic [TIMEOUT_W-1:0] wd_inc;
  logic                 dims_bad;

  // First set request at or after ptr, wrapping; the lowest offset wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] sel;
    int               j;
    sel = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) sel = j[IDX_W-1:0];
    end
    return sel;
  endfunction

  assign pick     = rr_pick(i_req, rr);
  assign wd_inc   = wd + TIMEOUT_W'(1);
  assign dims_bad = (o_f_row_size == '0) || (o_s_col_size == '0) ||
                    (o_f_col_size < DIM_W'(2));
  assign o_state  = state;

  always_ff @(posedge CLOCK_25) begin
    if (i_rst) begin
      state        <= S_IDLE;
      rr           <= '0;
      wd           <= '0;
      o_gnt        <= '0;
      o_done       <= '0;
      o_err        <= '0;
      o_start      <= 1'b0;
      o_f_row_size <= '0;
      o_f_col_size <= '0;
      o_s_col_size <= '0;
    end else begin
      o_done <= '0;
      o_err  <= '0;
      case (state)
        S_IDLE: begin
          // Grant and dimensions are registered here so they are visible in LOAD.
          if (|i_req) begin
            state        <= S_LOAD;
            o_gnt        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            o_f_row_size <= i_f_row_size[pick*DIM_W +: DIM_W];
            o_f_col_size <= i_f_col_size[pick*DIM_W +: DIM_W];
            o_s_col_size <= i_s_col_size[pick*DIM_W +: DIM_W];
            if (pick == IDX_W'(NUM_REQ - 1)) rr <= '0;
            else                             rr <= pick + 1'b1;
          end
        end
        S_LOAD: begin
          if (dims_bad) begin
            state <= S_REJECT;
          end else begin
            state   <= S_ARM;
            o_start <= 1'b1;
          end
        end
        S_ARM: begin
          if (i_eng_finished) begin
            state <= S_RUN;
            wd    <= '0;
          end
        end
        S_RUN: begin
          if (!(&wd)) wd <= wd_inc;
          if (i_eng_done) begin
            state   <= S_RELEASE;
            o_start <= 1'b0;
          end else if (&wd_inc) begin
            state   <= S_ABORT;
            o_start <= 1'b0;
          end
        end
        S_RELEASE: begin
          if (i_eng_finished) begin
            state  <= S_RESP_OK;
            o_done <= o_gnt;
          end
        end
        S_ABORT: begin
          if (i_eng_finished) begin
            state <= S_RESP_ERR;
            o_err <= o_gnt;
          end
        end
        S_REJECT: begin
          state <= S_RESP_ERR;
          o_err <= o_gnt;
        end
        S_RESP_OK, S_RESP_ERR: begin
          state <= S_IDLE;
          o_gnt <= '0;
        end
        default: begin
          state   <= S_IDLE;
          o_gnt   <= '0;
          o_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_job_arbiter.sv
// Directed bench for matrix_job_arbiter: a behavioural engine on the main instance,
// and a hand-driven engine on a short-watchdog instance for the timeout path.
module tb_matrix_job_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] frow, fcol, scol;
  logic [3:0]  gnt, done, err;
  logic        start;
  logic [7:0]  of_row, of_col, os_col;
  logic        eng_finished, eng_done;
  logic [3:0]  state;

  logic [3:0]  req_w;
  logic [31:0] frow_w, fcol_w, scol_w;
  logic [3:0]  gnt_w, done_w, err_w;
  logic        start_w;
  logic [7:0]  of_row_w, of_col_w, os_col_w;
  logic        fin_w;
  logic        edone_w;
  logic [3:0]  state_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_job_arbiter #(.NUM_REQ(4), .DIM_W(8), .TIMEOUT_W(16)) dut (
    .CLOCK_25(clk), .i_rst(rst), .i_req(req),
    .i_f_row_size(frow), .i_f_col_size(fcol), .i_s_col_size(scol),
    .o_gnt(gnt), .o_done(done), .o_err(err), .o_start(start),
    .o_f_row_size(of_row), .o_f_col_size(of_col), .o_s_col_size(os_col),
    .i_eng_finished(eng_finished), .i_eng_done(eng_done), .o_state(state)
  );

  matrix_job_arbiter #(.NUM_REQ(4), .DIM_W(8), .TIMEOUT_W(6)) dut_wd (
    .CLOCK_25(clk), .i_rst(rst), .i_req(req_w),
    .i_f_row_size(frow_w), .i_f_col_size(fcol_w), .i_s_col_size(scol_w),
    .o_gnt(gnt_w), .o_done(done_w), .o_err(err_w), .o_start(start_w),
    .o_f_row_size(of_row_w), .o_f_col_size(of_col_w), .o_s_col_size(os_col_w),
    .i_eng_finished(fin_w), .i_eng_done(edone_w), .o_state(state_w)
  );

  // Engine model: idle -> busy for eng_len cycles -> done until start drops -> idle.
  typedef enum logic [1:0] {E_IDLE, E_BUSY, E_DONE} eng_t;
  eng_t eng_st  = E_IDLE;
  int   eng_cnt = 0;
  int   eng_len = 10;

  assign eng_finished = (eng_st == E_IDLE);
  assign eng_done     = (eng_st == E_DONE);

  always @(posedge clk) begin
    if (rst) begin
      eng_st  <= E_IDLE;
      eng_cnt <= 0;
    end else begin
      case (eng_st)
        E_IDLE: if (start) begin eng_st <= E_BUSY; eng_cnt <= 1; end
        E_BUSY: begin
          if (!start)                eng_st <= E_IDLE;
          else if (eng_cnt >= eng_len) eng_st <= E_DONE;
          else                       eng_cnt <= eng_cnt + 1;
        end
        E_DONE: if (!start) eng_st <= E_IDLE;
        default: eng_st <= E_IDLE;
      endcase
    end
  end

  task automatic set_dims(input int k, input logic [7:0] r, input logic [7:0] c,
                          input logic [7:0] s);
    frow[k*8 +: 8] = r;
    fcol[k*8 +: 8] = c;
    scol[k*8 +: 8] = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pulse(input int budget, output int cyc, output logic ok,
                            output logic start_seen);
    ok = 1'b0; cyc = 0; start_seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc = i + 1;
      if (start) start_seen = 1'b1;
      if ((done | err) != 4'b0000) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (done !== 4'b0000 || err !== 4'b0000) begin
      bad++; $display("FAIL reset_pulses: done %b err %b want 0000 0000", done, err); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", start); end
    total++; if ({of_row, of_col, os_col} !== 24'h000000) begin
      bad++; $display("FAIL reset_dims: got %h want 000000", {of_row, of_col, os_col}); end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
  endtask

  task automatic test_single();
    logic ok, got;
    int   cyc, done_at, early;
    set_dims(0, 8'd4, 8'd4, 8'd4);
    eng_len = 80;
    req = 4'b0001;
    wait_gnt(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_wait_gnt: no grant within 200 cycles"); end
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    total++; if ({of_row, of_col, os_col} !== 24'h040404) begin
      bad++; $display("FAIL single_dims: got %h want 040404", {of_row, of_col, os_col}); end
    @(negedge clk);
    total++; if (start !== 1'b1) begin bad++; $display("FAIL single_start_latency: got %b want 1", start); end
    got = 1'b0; cyc = 0; done_at = -1; early = 0;
    for (int i = 0; i < 300; i++) begin
      if ((done | err) != 4'b0000) begin got = 1'b1; break; end
      if (eng_done && done_at < 0) done_at = cyc;
      if (done_at < 0 && !start) early++;
      @(negedge clk);
      cyc++;
    end
    total++; if (!got) begin bad++; $display("FAIL single_wait_done: no pulse within 300 cycles"); end
    total++; if (done !== 4'b0001 || err !== 4'b0000) begin
      bad++; $display("FAIL single_pulse: done %b err %b want 0001 0000", done, err); end
    total++; if (early != 0) begin bad++; $display("FAIL single_start_held: start low %0d cycles before done, want 0", early); end
    total++; if (cyc - done_at != 3) begin
      bad++; $display("FAIL single_done_latency: got %0d want 3", cyc - done_at); end
    req = 4'b0000;
    @(negedge clk);
    total++; if (done !== 4'b0000 || gnt !== 4'b0000) begin
      bad++; $display("FAIL single_after: done %b gnt %b want 0000 0000", done, gnt); end
  endtask

  task automatic test_round_robin();
    logic ok, ss;
    int   cyc;
    int   order [5];
    logic [3:0] want;
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 4; k++) set_dims(k, 8'd4, 8'd4, 8'd4);
    eng_len = 20;
    req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      want = 4'b0001 << order[p];
      wait_pulse(200, cyc, ok, ss);
      total++; if (!ok) begin bad++; $display("FAIL rr_wait_%0d: no pulse within 200 cycles", p); end
      total++; if (done !== want || err !== 4'b0000) begin
        bad++; $display("FAIL rr_order_%0d: done %b err %b want %b 0000", p, done, err, want); end
      if (p == 4) req = 4'b0000;
      @(negedge clk);
      total++; if (done !== 4'b0000) begin bad++; $display("FAIL rr_width_%0d: got %b want 0000", p, done); end
    end
  endtask

  task automatic test_reject();
    logic [7:0] vr [4];
    logic [7:0] vc [4];
    logic [7:0] vs [4];
    logic       verr [4];
    logic ok, ss;
    int   cyc;
    vr = '{8'd4, 8'd0, 8'd4, 8'd4};
    vc = '{8'd1, 8'd4, 8'd4, 8'd2};
    vs = '{8'd4, 8'd4, 8'd0, 8'd4};
    verr = '{1'b1, 1'b1, 1'b1, 1'b0};
    eng_len = 5;
    for (int v = 0; v < 4; v++) begin
      set_dims(2, vr[v], vc[v], vs[v]);
      req = 4'b0100;
      wait_gnt(ok);
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rej_gnt_%0d: got %b want 0100", v, gnt); end
      wait_pulse(100, cyc, ok, ss);
      if (verr[v]) begin
        total++; if (!ok || cyc != 2) begin
          bad++; $display("FAIL rej_latency_%0d: got %0d cycles want 2", v, cyc); end
        total++; if (err !== 4'b0100 || done !== 4'b0000) begin
          bad++; $display("FAIL rej_pulse_%0d: err %b done %b want 0100 0000", v, err, done); end
        total++; if (ss !== 1'b0) begin bad++; $display("FAIL rej_start_%0d: start rose, want never", v); end
      end else begin
        total++; if (!ok || done !== 4'b0100 || err !== 4'b0000) begin
          bad++; $display("FAIL rej_accept_%0d: done %b err %b want 0100 0000", v, done, err); end
        total++; if (ss !== 1'b1) begin bad++; $display("FAIL rej_accept_start_%0d: start never rose", v); end
      end
      req = 4'b0000;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    logic got;
    int   hi;
    frow_w[16 +: 8] = 8'd4; fcol_w[16 +: 8] = 8'd4; scol_w[16 +: 8] = 8'd4;
    fin_w = 1'b1;
    req_w = 4'b0100;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (start_w) begin got = 1'b1; break; end
    end
    total++; if (!got) begin bad++; $display("FAIL wd_start: start never rose"); end
    total++; if (gnt_w !== 4'b0100) begin bad++; $display("FAIL wd_gnt: got %b want 0100", gnt_w); end
    hi = 1;
    @(negedge clk);
    fin_w = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!start_w) break;
      hi++;
      @(negedge clk);
    end
    total++; if (hi != 64) begin bad++; $display("FAIL wd_run_len: start high %0d cycles want 64", hi); end
    repeat (3) @(negedge clk);
    total++; if (err_w !== 4'b0000 || start_w !== 1'b0) begin
      bad++; $display("FAIL wd_abort_wait: err %b start %b want 0000 0", err_w, start_w); end
    fin_w = 1'b1;
    @(negedge clk);
    total++; if (err_w !== 4'b0100 || done_w !== 4'b0000) begin
      bad++; $display("FAIL wd_err: err %b done %b want 0100 0000", err_w, done_w); end
    req_w = 4'b0000;
    @(negedge clk);
    total++; if (err_w !== 4'b0000) begin bad++; $display("FAIL wd_err_width: got %b want 0000", err_w); end
  endtask

  task automatic test_reset_mid_run();
    logic ok, ss;
    int   cyc;
    set_dims(0, 8'd4, 8'd4, 8'd4); set_dims(1, 8'd4, 8'd4, 8'd4); set_dims(3, 8'd4, 8'd4, 8'd4);
    eng_len = 80;
    req = 4'b0010;
    wait_gnt(ok);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rst_first_gnt: got %b want 0010", gnt); end
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (start !== 1'b0 || gnt !== 4'b0000 || (done | err) !== 4'b0000) begin
      bad++; $display("FAIL rst_abort: start %b gnt %b done %b err %b want 0 0000 0000 0000",
                      start, gnt, done, err); end
    rst = 1'b0;
    req = 4'b1001;
    wait_gnt(ok);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_next_gnt: got %b want 0001", gnt); end
    wait_pulse(300, cyc, ok, ss);
    total++; if (!ok || done !== 4'b0001) begin bad++; $display("FAIL rst_next_done: got %b want 0001", done); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_drop_mid_job();
    logic ok, ss;
    int   cyc;
    eng_len = 30;
    req = 4'b0010;
    wait_gnt(ok);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL drop_gnt: got %b want 0010", gnt); end
    repeat (6) @(negedge clk);
    req = 4'b1000;
    wait_pulse(300, cyc, ok, ss);
    total++; if (!ok || done !== 4'b0010 || err !== 4'b0000) begin
      bad++; $display("FAIL drop_done: done %b err %b want 0010 0000", done, err); end
    wait_gnt(ok);
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL drop_next_gnt: got %b want 1000", gnt); end
    wait_pulse(300, cyc, ok, ss);
    total++; if (!ok || done !== 4'b1000) begin bad++; $display("FAIL drop_next_done: got %b want 1000", done); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req = '0; frow = '0; fcol = '0; scol = '0;
    req_w = '0; frow_w = '0; fcol_w = '0; scol_w = '0;
    fin_w = 1'b1; edone_w = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_single();
    do_reset();
    test_round_robin();
    test_reject();
    test_timeout();
    test_reset_mid_run();
    test_drop_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
